// File: rtl/modem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : modem_pkg
// Brief    : Shared state encoding, framing constants and CRC-16 helper.
// Revision : 1.0
// ============================================================================
package modem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SYNC = 3'd2,
        ST_DATA = 3'd3,
        ST_CRC  = 3'd4,
        ST_CW   = 3'd5,
        ST_DONE = 3'd6
    } tx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'hAA;
    localparam logic [15:0] CRC_POLY      = 16'h1021;
    localparam logic [15:0] CRC_INIT      = 16'hFFFF;

    // CRC-16-CCITT, MSB first, one byte per call.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                               input logic [7:0]  data);
        logic [15:0] c;
        c = crc_in ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_framer_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : bit_timer
// Brief    : Bit-period counter producing start-of-bit and end-of-bit strobes.
// Revision : 1.0
// ============================================================================
module bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    output logic o_stb,
    output logic o_end
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Held at zero while disabled so the first enabled cycle is always bit start.
    always_comb begin
        cnt_d = '0;
        if (i_en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_stb = i_en && (cnt_q == '0);
    assign o_end = i_en && (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tx_framer
// Brief    : Serial frame generator: preamble, sync, RAM payload, optional CRC.
//            Define TX_CRC16_EN to append a CRC-16-CCITT after the payload.
// Revision : 1.0
// ============================================================================
module tx_framer
    import modem_pkg::*;
#(
    parameter int          CLKS_PER_BIT   = 16,
    parameter int          PREAMBLE_BYTES = 4,
    parameter logic [15:0] SYNC_WORD      = 16'h2DD4,
    parameter int          RAM_DEPTH      = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_transmit,
    input  logic [9:0] i_msg_length,
    input  logic       i_cw,
    output logic       o_ram_rd,
    output logic [9:0] o_ram_addr,
    input  logic [7:0] i_ram_data,
    output logic       o_bit,
    output logic       o_bit_stb,
    output logic       o_cw,
    output logic       o_tx_active,
    output logic       o_tx_done
);

    localparam logic [9:0] DEPTH_MAX = 10'(RAM_DEPTH);
    localparam logic [9:0] PRE_LAST  = 10'(PREAMBLE_BYTES - 1);

    tx_state_e  state_q, state_d;
    logic       trans_q;
    logic [9:0] len_q, len_d;
    logic [9:0] byte_cnt_q, byte_cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] next_byte_q;
    logic       rd_q, rd_d;
    logic       rd_pend_q;
    logic [9:0] addr_q, addr_d;
    logic       done_q, done_d;

    logic       w_start;
    logic [9:0] w_len;
    logic       w_bit_en;
    logic       w_stb;
    logic       w_end;
    logic       w_byte_end;
    logic       w_last_byte;
    logic       w_more;
    logic [9:0] w_next_addr;

    assign w_start     = (state_q == ST_IDLE) && i_transmit && !trans_q;
    assign w_len       = (i_msg_length > DEPTH_MAX) ? DEPTH_MAX : i_msg_length;
    assign w_bit_en    = (state_q == ST_PRE)  || (state_q == ST_SYNC) ||
                         (state_q == ST_DATA) || (state_q == ST_CRC)  ||
                         (state_q == ST_CW);
    assign w_byte_end  = w_end && (bit_idx_q == 3'd7);
    assign w_last_byte = (byte_cnt_q == (len_q - 10'd1));
    assign w_next_addr = byte_cnt_q + 10'd1;
    assign w_more      = (({1'b0, byte_cnt_q} + 11'd1) < {1'b0, len_q});

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_bit_en),
        .o_stb (w_stb),
        .o_end (w_end)
    );

`ifdef TX_CRC16_EN
    logic [15:0] crc_q;
    logic        w_load_data;

    // CRC advances whenever a payload byte is moved into the shift register.
    assign w_load_data = w_byte_end &&
                         (((state_q == ST_SYNC) && (byte_cnt_q != 10'd0)) ||
                          ((state_q == ST_DATA) && !w_last_byte));

    always_ff @(posedge clk) begin
        if (reset || w_start) begin
            crc_q <= CRC_INIT;
        end else if (w_load_data) begin
            crc_q <= crc16_byte(crc_q, next_byte_q);
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        rd_d       = 1'b0;
        addr_d     = addr_q;
        done_d     = 1'b0;

        // Rotate keeps an all-ones carrier byte intact in CW mode.
        if (w_end && !w_byte_end) begin
            bit_idx_d = bit_idx_q + 3'd1;
            shreg_d   = {shreg_q[6:0], shreg_q[7]};
        end

        case (state_q)
            ST_IDLE: begin
                addr_d     = '0;
                shreg_d    = '0;
                byte_cnt_d = '0;
                bit_idx_d  = '0;
                if (w_start) begin
                    len_d = w_len;
                    if (w_len == 10'd0) begin
                        state_d = ST_DONE;
                    end else if (i_cw) begin
                        state_d = ST_CW;
                        shreg_d = 8'hFF;
                    end else begin
                        state_d = ST_PRE;
                        shreg_d = PREAMBLE_BYTE;
                    end
                end
            end
            ST_PRE: begin
                if (w_byte_end) begin
                    bit_idx_d = '0;
                    if (byte_cnt_q == PRE_LAST) begin
                        state_d    = ST_SYNC;
                        byte_cnt_d = '0;
                        shreg_d    = SYNC_WORD[15:8];
                    end else begin
                        byte_cnt_d = byte_cnt_q + 10'd1;
                        shreg_d    = PREAMBLE_BYTE;
                    end
                end
            end
            ST_SYNC: begin
                if (w_stb && (byte_cnt_q == 10'd0) && (bit_idx_q == 3'd0)) begin
                    rd_d   = 1'b1;
                    addr_d = '0;
                end
                if (w_byte_end) begin
                    bit_idx_d = '0;
                    if (byte_cnt_q == 10'd0) begin
                        byte_cnt_d = 10'd1;
                        shreg_d    = SYNC_WORD[7:0];
                    end else begin
                        state_d    = ST_DATA;
                        byte_cnt_d = '0;
                        shreg_d    = next_byte_q;
                    end
                end
            end
            ST_DATA: begin
                if (w_stb && (bit_idx_q == 3'd0) && w_more) begin
                    rd_d   = 1'b1;
                    addr_d = w_next_addr;
                end
                if (w_byte_end) begin
                    bit_idx_d = '0;
                    if (w_last_byte) begin
`ifdef TX_CRC16_EN
                        state_d    = ST_CRC;
                        byte_cnt_d = '0;
                        shreg_d    = crc_q[15:8];
`else
                        state_d    = ST_DONE;
                        shreg_d    = '0;
`endif
                    end else begin
                        byte_cnt_d = byte_cnt_q + 10'd1;
                        shreg_d    = next_byte_q;
                    end
                end
            end
`ifdef TX_CRC16_EN
            ST_CRC: begin
                if (w_byte_end) begin
                    bit_idx_d = '0;
                    if (byte_cnt_q == 10'd0) begin
                        byte_cnt_d = 10'd1;
                        shreg_d    = crc_q[7:0];
                    end else begin
                        state_d = ST_DONE;
                        shreg_d = '0;
                    end
                end
            end
`endif
            ST_CW: begin
                if (w_byte_end) begin
                    bit_idx_d = '0;
                    if (w_last_byte) begin
                        state_d = ST_DONE;
                        shreg_d = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 10'd1;
                    end
                end
            end
            ST_DONE: begin
                done_d     = 1'b1;
                state_d    = ST_IDLE;
                shreg_d    = '0;
                byte_cnt_d = '0;
                bit_idx_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                shreg_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            trans_q     <= i_transmit;
            len_q       <= '0;
            byte_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            next_byte_q <= '0;
            rd_q        <= 1'b0;
            rd_pend_q   <= 1'b0;
            addr_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            trans_q    <= i_transmit;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            rd_q       <= rd_d;
            rd_pend_q  <= rd_q;
            addr_q     <= addr_d;
            done_q     <= done_d;
            if (rd_pend_q) begin
                next_byte_q <= i_ram_data;
            end
        end
    end

    assign o_bit       = shreg_q[7];
    assign o_bit_stb   = w_stb;
    assign o_cw        = (state_q == ST_CW);
    assign o_tx_active = (state_q != ST_IDLE);
    assign o_tx_done   = done_q;
    assign o_ram_rd    = rd_q;
    assign o_ram_addr  = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_framer
// Brief    : Directed table-driven bench for tx_framer plus multi-cycle cases.
// Revision : 1.0
// ============================================================================
module tb_tx_framer;

    localparam int CRC_B =
`ifdef TX_CRC16_EN
        2;
`else
        0;
`endif

    typedef struct {
        int len;
        bit cw;
        int lat;
        int nbits;
        int nreads;
        int cwcyc;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       i_transmit;
    logic [9:0] i_msg_length;
    logic       i_cw;
    logic       o_ram_rd;
    logic [9:0] o_ram_addr;
    logic [7:0] ram_data;
    logic       o_bit;
    logic       o_bit_stb;
    logic       o_cw;
    logic       o_tx_active;
    logic       o_tx_done;

    logic       f_transmit;
    logic [9:0] f_msg_length;
    logic       f_ram_rd;
    logic [9:0] f_ram_addr;
    logic [7:0] f_ram_data;
    logic       f_bit;
    logic       f_bit_stb;
    logic       f_cw;
    logic       f_tx_active;
    logic       f_tx_done;

    logic [7:0] mem [0:1023];
    bit         bits_log[$];
    int         rd_log[$];
    bit         exp_bits[$];
    int         done_cnt, cw_cyc, cw_bad;
    int         f_reads, f_first, f_last, f_done_cnt;
    int         checks, errors;

    tx_framer u_dut (
        .clk          (clk),
        .reset        (reset),
        .i_transmit   (i_transmit),
        .i_msg_length (i_msg_length),
        .i_cw         (i_cw),
        .o_ram_rd     (o_ram_rd),
        .o_ram_addr   (o_ram_addr),
        .i_ram_data   (ram_data),
        .o_bit        (o_bit),
        .o_bit_stb    (o_bit_stb),
        .o_cw         (o_cw),
        .o_tx_active  (o_tx_active),
        .o_tx_done    (o_tx_done)
    );

    // Short bit period so a full clamped-length frame stays cheap to simulate.
    tx_framer #(.CLKS_PER_BIT(4)) u_dut_fast (
        .clk          (clk),
        .reset        (reset),
        .i_transmit   (f_transmit),
        .i_msg_length (f_msg_length),
        .i_cw         (1'b0),
        .o_ram_rd     (f_ram_rd),
        .o_ram_addr   (f_ram_addr),
        .i_ram_data   (f_ram_data),
        .o_bit        (f_bit),
        .o_bit_stb    (f_bit_stb),
        .o_cw         (f_cw),
        .o_tx_active  (f_tx_active),
        .o_tx_done    (f_tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_ram_rd) ram_data <= mem[o_ram_addr];
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (o_bit_stb) bits_log.push_back(o_bit);
            if (o_ram_rd) rd_log.push_back(int'(o_ram_addr));
            if (o_tx_done) done_cnt++;
            if (o_cw) cw_cyc++;
            if (o_cw && !o_bit) cw_bad++;
            if (f_ram_rd) begin
                f_reads++;
                f_last = int'(f_ram_addr);
                if (f_reads == 1) f_first = int'(f_ram_addr);
            end
            if (f_tx_done) f_done_cnt++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
    endtask

`ifdef TX_CRC16_EN
    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ b[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction
`endif

    task automatic build_exp(input int len, input bit cw);
        logic [15:0] crc;
        exp_bits.delete();
        crc = 16'hFFFF;
        if (len == 0) return;
        if (cw) begin
            for (int i = 0; i < len * 8; i++) exp_bits.push_back(1'b1);
            return;
        end
        for (int i = 0; i < 4; i++) push_byte(8'hAA);
        push_byte(8'h2D);
        push_byte(8'hD4);
        for (int i = 0; i < len; i++) begin
            push_byte(mem[i]);
`ifdef TX_CRC16_EN
            crc = crc_model(crc, mem[i]);
`endif
        end
`ifdef TX_CRC16_EN
        push_byte(crc[15:8]);
        push_byte(crc[7:0]);
`endif
    endtask

    task automatic run_frame(input vec_t v, input int hold, input string tag);
        int lat;
        bit seen;
        bit act_at_done;
        int nbad;
        int n;
        i_msg_length = 10'(v.len);
        i_cw         = v.cw;
        bits_log.delete();
        rd_log.delete();
        done_cnt = 0;
        cw_cyc   = 0;
        cw_bad   = 0;
        build_exp(v.len, v.cw);
        @(posedge clk);
        #1 i_transmit = 1'b1;
        lat = 0;
        seen = 0;
        act_at_done = 1'b1;
        while (!seen && lat < 4000) begin
            @(posedge clk);
            #1;
            lat++;
            if (o_tx_done) begin
                seen = 1'b1;
                act_at_done = o_tx_active;
            end
        end
        chk({tag, " done latency"}, seen ? lat : -1, v.lat);
        chk({tag, " active at done"}, int'(act_at_done), 0);
        repeat (hold) @(posedge clk);
        #1;
        chk({tag, " bit count"}, bits_log.size(), v.nbits);
        chk({tag, " read count"}, rd_log.size(), v.nreads);
        chk({tag, " done pulses"}, done_cnt, 1);
        nbad = 0;
        n = (bits_log.size() < exp_bits.size()) ? bits_log.size() : exp_bits.size();
        for (int i = 0; i < n; i++) if (bits_log[i] != exp_bits[i]) nbad++;
        chk({tag, " bit errors"}, nbad, 0);
        nbad = 0;
        for (int i = 0; i < rd_log.size(); i++) if (rd_log[i] != i) nbad++;
        chk({tag, " read addr errors"}, nbad, 0);
        chk({tag, " cw cycles"}, cw_cyc, v.cwcyc);
        chk({tag, " cw low bits"}, cw_bad, 0);
        i_transmit = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin : main
        vec_t vecs[4];
        int   n;
        int   nb;
        checks = 0;
        errors = 0;
        done_cnt = 0;
        cw_cyc = 0;
        cw_bad = 0;
        f_reads = 0;
        f_first = -1;
        f_last = -1;
        f_done_cnt = 0;
        ram_data = 8'h00;
        f_ram_data = 8'h00;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[0] = 8'h01;
        mem[1] = 8'h80;
        mem[2] = 8'hFF;

        // {len, cw, done latency from edge, bit strobes, RAM reads, o_cw cycles}
        vecs[0] = '{3, 1'b0, 1154 + CRC_B * 128, 72 + CRC_B * 8, 3, 0};
        vecs[1] = '{0, 1'b0, 2, 0, 0, 0};
        vecs[2] = '{2, 1'b1, 258, 16, 0, 256};
        vecs[3] = '{1, 1'b0, 898 + CRC_B * 128, 56 + CRC_B * 8, 1, 0};

        reset = 1'b1;
        i_transmit = 1'b0;
        i_msg_length = 10'd0;
        i_cw = 1'b0;
        f_transmit = 1'b0;
        f_msg_length = 10'd0;
        repeat (4) @(posedge clk);
        #1;
        chk("reset outputs", int'({o_bit, o_bit_stb, o_cw, o_tx_active, o_tx_done, o_ram_rd}), 0);
        chk("reset addr", int'(o_ram_addr), 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 4; i++) run_frame(vecs[i], 20, $sformatf("vec%0d", i));

        run_frame(vecs[3], 5000, "held level");

        // Reset during DATA byte 1: read for address 2 has just gone out.
        i_msg_length = 10'd3;
        i_cw = 1'b0;
        bits_log.delete();
        rd_log.delete();
        done_cnt = 0;
        @(posedge clk);
        #1 i_transmit = 1'b1;
        n = 0;
        while (rd_log.size() < 3 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("midreset reached byte1", rd_log.size(), 3);
        repeat (8) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset o_bit", int'(o_bit), 0);
        chk("midreset o_tx_active", int'(o_tx_active), 0);
        chk("midreset o_ram_addr", int'(o_ram_addr), 0);
        reset = 1'b0;
        nb = bits_log.size();
        repeat (300) @(posedge clk);
        #1;
        chk("midreset no done", done_cnt, 0);
        chk("midreset no restart", bits_log.size(), nb);
        i_transmit = 1'b0;
        repeat (2) @(posedge clk);
        run_frame(vecs[0], 20, "after reset");

`ifdef TX_CRC16_EN
        begin
            logic [71:0] s;
            logic [15:0] got;
            vec_t        cv;
            s = "123456789";
            for (int i = 0; i < 9; i++) mem[i] = s[71 - 8 * i -: 8];
            cv = '{9, 1'b0, 2178, 136, 9, 0};
            run_frame(cv, 20, "crc check");
            got = '0;
            if (bits_log.size() >= 16) begin
                for (int i = 0; i < 16; i++) got[15 - i] = bits_log[bits_log.size() - 16 + i];
            end
            chk("crc value", int'(got), 32'h29B1);
        end
`endif

        f_msg_length = 10'd1023;
        @(posedge clk);
        #1 f_transmit = 1'b1;
        n = 0;
        while (f_done_cnt == 0 && n < 40000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("clamp done", f_done_cnt, 1);
        chk("clamp reads", f_reads, 1000);
        chk("clamp first addr", f_first, 0);
        chk("clamp last addr", f_last, 999);
        f_transmit = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
